// File: rtl/iomem_periph.sv
// iomem_periph: GPIO and timer responder on the iomem bus.
// The peripheral acknowledges only accesses inside its 256-byte window.
// Each access is answered with a registered ready pulse that rises one cycle after the request.
// Writes commit at the edge that raises ready, and read data is captured at that same edge.
module iomem_periph #(
  parameter logic [31:0] BASE_ADDR  = 32'h0300_0000,
  parameter int          GPIO_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  iomem_valid,
  output logic                  iomem_ready,
  input  logic [3:0]            iomem_wstrb,
  input  logic [31:0]           iomem_addr,
  input  logic [31:0]           iomem_wdata,
  output logic [31:0]           iomem_rdata,
  output logic [GPIO_WIDTH-1:0] gpio_out,
  input  logic [GPIO_WIDTH-1:0] gpio_in,
  output logic                  irq_timer,
  output logic                  irq_gpio
);

  localparam logic [5:0] REG_GPIO_OUT  = 6'd0;
  localparam logic [5:0] REG_GPIO_IN   = 6'd1;
  localparam logic [5:0] REG_GPIO_IEN  = 6'd2;
  localparam logic [5:0] REG_GPIO_STAT = 6'd3;
  localparam logic [5:0] REG_TMR_CTRL  = 6'd4;
  localparam logic [5:0] REG_TMR_LOAD  = 6'd5;
  localparam logic [5:0] REG_TMR_COUNT = 6'd6;
  localparam logic [5:0] REG_TMR_STAT  = 6'd7;

  // bus state
  logic                  ready_q, ready_d;
  logic [31:0]           rdata_q, rdata_d;

  // gpio state
  logic [GPIO_WIDTH-1:0] gpio_out_q, gpio_out_d;
  logic [GPIO_WIDTH-1:0] sync1_q, sync1_d;
  logic [GPIO_WIDTH-1:0] sync2_q, sync2_d;
  logic [GPIO_WIDTH-1:0] prev_q, prev_d;
  logic [GPIO_WIDTH-1:0] gpio_ien_q, gpio_ien_d;
  logic [GPIO_WIDTH-1:0] gpio_stat_q, gpio_stat_d;
  logic                  irq_gpio_q, irq_gpio_d;

  // timer state
  logic                  tmr_en_q, tmr_en_d;
  logic                  tmr_reload_q, tmr_reload_d;
  logic                  tmr_ien_q, tmr_ien_d;
  logic [31:0]           tmr_load_q, tmr_load_d;
  logic [31:0]           tmr_count_q, tmr_count_d;
  logic                  tmr_expired_q, tmr_expired_d;
  logic                  irq_timer_q, irq_timer_d;

  // decode and helper signals
  logic                  in_window;
  logic                  sel;
  logic                  wr_en;
  logic                  rd_en;
  logic [5:0]            reg_idx;
  logic [31:0]           byte_mask;
  logic [31:0]           read_val;
  logic [31:0]           load_merged;
  logic [GPIO_WIDTH-1:0] gpio_rise;
  logic [GPIO_WIDTH-1:0] gpio_clr;
  logic                  tmr_set;
  logic                  tmr_clr;
  logic                  unused_addr_bits;

  assign unused_addr_bits = ^iomem_addr[1:0];

  function automatic logic [31:0] zext_gpio(input logic [GPIO_WIDTH-1:0] v);
    logic [31:0] r;
    r = '0;
    r[GPIO_WIDTH-1:0] = v;
    return r;
  endfunction

  // Decode the request and expand the byte strobes into a bit mask.
  always_comb begin
    in_window = (iomem_addr[31:8] == BASE_ADDR[31:8]);
    sel       = iomem_valid && in_window && !ready_q;
    wr_en     = sel && (iomem_wstrb != 4'b0000);
    rd_en     = sel && (iomem_wstrb == 4'b0000);
    reg_idx   = iomem_addr[7:2];
    byte_mask = {{8{iomem_wstrb[3]}}, {8{iomem_wstrb[2]}},
                 {8{iomem_wstrb[1]}}, {8{iomem_wstrb[0]}}};
    gpio_rise = sync2_q & ~prev_q;
  end

  // Read mux. Unused bits and unmapped offsets read as zero.
  always_comb begin
    read_val = '0;
    case (reg_idx)
      REG_GPIO_OUT:  read_val = zext_gpio(gpio_out_q);
      REG_GPIO_IN:   read_val = zext_gpio(sync2_q);
      REG_GPIO_IEN:  read_val = zext_gpio(gpio_ien_q);
      REG_GPIO_STAT: read_val = zext_gpio(gpio_stat_q);
      REG_TMR_CTRL:  read_val = {29'd0, tmr_ien_q, tmr_reload_q, tmr_en_q};
      REG_TMR_LOAD:  read_val = tmr_load_q;
      REG_TMR_COUNT: read_val = tmr_count_q;
      REG_TMR_STAT:  read_val = {31'd0, tmr_expired_q};
      default:       read_val = '0;
    endcase
  end

  // Next state for bus, registers, gpio edge detection and timer.
  // Bus writes are applied after the timer step so that a write takes priority over it.
  // For the W1C status bits, a new set takes priority over a clear.
  always_comb begin
    ready_d       = sel;
    rdata_d       = rd_en ? read_val : 32'd0;
    gpio_out_d    = gpio_out_q;
    sync1_d       = gpio_in;
    sync2_d       = sync1_q;
    prev_d        = sync2_q;
    gpio_ien_d    = gpio_ien_q;
    gpio_stat_d   = gpio_stat_q;
    irq_gpio_d    = |gpio_stat_q;
    tmr_en_d      = tmr_en_q;
    tmr_reload_d  = tmr_reload_q;
    tmr_ien_d     = tmr_ien_q;
    tmr_load_d    = tmr_load_q;
    tmr_count_d   = tmr_count_q;
    tmr_expired_d = tmr_expired_q;
    irq_timer_d   = tmr_expired_q & tmr_ien_q;
    tmr_set       = 1'b0;
    tmr_clr       = 1'b0;
    gpio_clr      = '0;
    load_merged   = (tmr_load_q & ~byte_mask) | (iomem_wdata & byte_mask);

    if (tmr_en_q && (tmr_count_q != 32'd0)) begin
      if (tmr_count_q == 32'd1) begin
        tmr_set = 1'b1;
        if (tmr_reload_q) begin
          tmr_count_d = tmr_load_q;
        end else begin
          tmr_count_d = 32'd0;
          tmr_en_d    = 1'b0;
        end
      end else begin
        tmr_count_d = tmr_count_q - 32'd1;
      end
    end

    if (wr_en) begin
      case (reg_idx)
        REG_GPIO_OUT:
          gpio_out_d = (gpio_out_q & ~byte_mask[GPIO_WIDTH-1:0]) |
                       (iomem_wdata[GPIO_WIDTH-1:0] & byte_mask[GPIO_WIDTH-1:0]);
        REG_GPIO_IEN:
          gpio_ien_d = (gpio_ien_q & ~byte_mask[GPIO_WIDTH-1:0]) |
                       (iomem_wdata[GPIO_WIDTH-1:0] & byte_mask[GPIO_WIDTH-1:0]);
        REG_GPIO_STAT:
          gpio_clr = iomem_wdata[GPIO_WIDTH-1:0] & byte_mask[GPIO_WIDTH-1:0];
        REG_TMR_CTRL:
          if (iomem_wstrb[0]) begin
            tmr_en_d     = iomem_wdata[0];
            tmr_reload_d = iomem_wdata[1];
            tmr_ien_d    = iomem_wdata[2];
          end
        REG_TMR_LOAD: begin
          tmr_load_d  = load_merged;
          tmr_count_d = load_merged;
        end
        REG_TMR_STAT:
          tmr_clr = iomem_wstrb[0] && iomem_wdata[0];
        default: ;
      endcase
    end

    gpio_stat_d   = (gpio_stat_q & ~gpio_clr) | (gpio_rise & gpio_ien_q);
    tmr_expired_d = (tmr_expired_q & ~tmr_clr) | tmr_set;
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      ready_q       <= 1'b0;
      rdata_q       <= '0;
      gpio_out_q    <= '0;
      sync1_q       <= '0;
      sync2_q       <= '0;
      prev_q        <= '0;
      gpio_ien_q    <= '0;
      gpio_stat_q   <= '0;
      irq_gpio_q    <= 1'b0;
      tmr_en_q      <= 1'b0;
      tmr_reload_q  <= 1'b0;
      tmr_ien_q     <= 1'b0;
      tmr_load_q    <= '0;
      tmr_count_q   <= '0;
      tmr_expired_q <= 1'b0;
      irq_timer_q   <= 1'b0;
    end else begin
      ready_q       <= ready_d;
      rdata_q       <= rdata_d;
      gpio_out_q    <= gpio_out_d;
      sync1_q       <= sync1_d;
      sync2_q       <= sync2_d;
      prev_q        <= prev_d;
      gpio_ien_q    <= gpio_ien_d;
      gpio_stat_q   <= gpio_stat_d;
      irq_gpio_q    <= irq_gpio_d;
      tmr_en_q      <= tmr_en_d;
      tmr_reload_q  <= tmr_reload_d;
      tmr_ien_q     <= tmr_ien_d;
      tmr_load_q    <= tmr_load_d;
      tmr_count_q   <= tmr_count_d;
      tmr_expired_q <= tmr_expired_d;
      irq_timer_q   <= irq_timer_d;
    end
  end

  assign iomem_ready = ready_q;
  assign iomem_rdata = rdata_q;
  assign gpio_out    = gpio_out_q;
  assign irq_timer   = irq_timer_q;
  assign irq_gpio    = irq_gpio_q;

endmodule

// File: tb/tb_iomem_periph.sv
// Testbench for iomem_periph.
// Each bus access pushes its expected response onto a scoreboard queue.
// A negedge monitor pops an entry and compares it whenever ready is high.
module tb_iomem_periph;

  localparam logic [31:0] BASE  = 32'h0300_0000;
  localparam int          GW    = 16;
  localparam logic [31:0] GMASK = 32'h0000_FFFF;

  logic          clk;
  logic          resetn;
  logic          iomem_valid;
  logic          iomem_ready;
  logic [3:0]    iomem_wstrb;
  logic [31:0]   iomem_addr;
  logic [31:0]   iomem_wdata;
  logic [31:0]   iomem_rdata;
  logic [GW-1:0] gpio_out;
  logic [GW-1:0] gpio_in;
  logic          irq_timer;
  logic          irq_gpio;

  iomem_periph #(.BASE_ADDR(BASE), .GPIO_WIDTH(GW)) dut (
    .clk         (clk),
    .resetn      (resetn),
    .iomem_valid (iomem_valid),
    .iomem_ready (iomem_ready),
    .iomem_wstrb (iomem_wstrb),
    .iomem_addr  (iomem_addr),
    .iomem_wdata (iomem_wdata),
    .iomem_rdata (iomem_rdata),
    .gpio_out    (gpio_out),
    .gpio_in     (gpio_in),
    .irq_timer   (irq_timer),
    .irq_gpio    (irq_gpio)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // free-running edge counter used to place events in time
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit          is_read;
    logic [31:0] data;
    string       name;
  } sb_item_t;

  sb_item_t sb_q[$];
  sb_item_t mon_item;
  bit       mon_en = 1'b0;
  int       last_cap;

  // timer reference: counting started after edge tm_en_edge from value tm_load
  int tm_load;
  int tm_en_edge;
  bit tm_reload;

  // Expected COUNT value as seen at capture edge cap, which is the value left by edge cap-1.
  function automatic logic [31:0] timer_count_at(int cap);
    int k;
    k = cap - 1 - tm_en_edge;
    if (k < 0) return 32'(tm_load);
    if (!tm_reload) return (k >= tm_load) ? 32'd0 : 32'(tm_load - k);
    if (tm_load == 0) return 32'd0;
    return 32'(tm_load - (k % tm_load));
  endfunction

  function automatic logic [31:0] merge_bytes(logic [31:0] old, logic [31:0] data, logic [3:0] strb);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++)
      if (strb[b]) r[b*8 +: 8] = data[b*8 +: 8];
    return r;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Issues one access. In-window accesses must be acknowledged exactly one edge later.
  // Out-of-window accesses must never be acknowledged.
  task automatic applyStimulus(input logic [31:0] addr, input logic [3:0] strb,
                               input logic [31:0] wdata, input logic [31:0] exp,
                               input bit use_timer, input bit in_win, input bit hold,
                               input string name);
    sb_item_t it;
    @(posedge clk);
    #1;
    iomem_valid = 1'b1;
    iomem_addr  = addr;
    iomem_wstrb = strb;
    iomem_wdata = wdata;
    last_cap    = cyc + 1;
    if (in_win) begin
      it.is_read = (strb == 4'b0000);
      it.data    = use_timer ? timer_count_at(last_cap) : exp;
      it.name    = name;
      sb_q.push_back(it);
      @(posedge clk);
      #1;
      checkOutput({name, "_ack"}, {31'd0, iomem_ready}, 32'd1);
      if (hold) begin
        @(posedge clk);
        #1;
        checkOutput({name, "_no_second_ack"}, {31'd0, iomem_ready}, 32'd0);
      end
    end else begin
      repeat (3) begin
        @(posedge clk);
        #1;
        checkOutput({name, "_no_ack"}, {31'd0, iomem_ready}, 32'd0);
      end
    end
    iomem_valid = 1'b0;
    iomem_wstrb = 4'b0000;
  endtask

  task automatic busWrite(input logic [7:0] off, input logic [3:0] strb,
                          input logic [31:0] d, input string name);
    applyStimulus(BASE | {24'd0, off}, strb, d, 32'd0, 1'b0, 1'b1, 1'b0, name);
  endtask

  task automatic busRead(input logic [7:0] off, input logic [31:0] exp, input string name);
    applyStimulus(BASE | {24'd0, off}, 4'b0000, 32'd0, exp, 1'b0, 1'b1, 1'b0, name);
  endtask

  task automatic readCount(input string name);
    applyStimulus(BASE | 32'h18, 4'b0000, 32'd0, 32'd0, 1'b1, 1'b1, 1'b0, name);
  endtask

  // scoreboard monitor: pop on every ready pulse, otherwise rdata must be zero
  always @(negedge clk) begin
    if (mon_en) begin
      if (iomem_ready) begin
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL ready_without_request: actual ready=1 required ready=0");
        end else begin
          mon_item = sb_q.pop_front();
          if (mon_item.is_read) checkOutput(mon_item.name, iomem_rdata, mon_item.data);
        end
      end else begin
        checkOutput("rdata_idle_zero", iomem_rdata, 32'd0);
      end
    end
  end

  initial begin
    #3_000_000;
    $display("[TB] FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [31:0] mdl_out;
    logic [31:0] mdl_ien;
    logic [31:0] d;
    logic [31:0] a;
    logic [3:0]  s;
    int          op;

    resetn      = 1'b0;
    iomem_valid = 1'b0;
    iomem_wstrb = 4'b0000;
    iomem_addr  = 32'd0;
    iomem_wdata = 32'd0;
    gpio_in     = '0;
    mdl_out     = 32'd0;
    mdl_ien     = 32'd0;

    idle(3);
    checkOutput("reset_ready", {31'd0, iomem_ready}, 32'd0);
    checkOutput("reset_rdata", iomem_rdata, 32'd0);
    checkOutput("reset_gpio_out", 32'(gpio_out), 32'd0);
    checkOutput("reset_irq_timer", {31'd0, irq_timer}, 32'd0);
    checkOutput("reset_irq_gpio", {31'd0, irq_gpio}, 32'd0);
    resetn = 1'b1;
    mon_en = 1'b1;

    // randomized register traffic against a simple register model
    for (int i = 0; i < 60; i++) begin
      op = int'($urandom_range(0, 6));
      d  = $urandom;
      s  = 4'($urandom_range(1, 15));
      case (op)
        0: begin
          busWrite(8'h00, s, d, "rnd_wr_gpio_out");
          mdl_out = merge_bytes(mdl_out, d, s) & GMASK;
          checkOutput("rnd_gpio_out_pins", 32'(gpio_out), mdl_out);
        end
        1: busRead(8'h00, mdl_out, "rnd_rd_gpio_out");
        2: begin
          busWrite(8'h08, s, d, "rnd_wr_ien");
          mdl_ien = merge_bytes(mdl_ien, d, s) & GMASK;
        end
        3: busRead(8'h08, mdl_ien, "rnd_rd_ien");
        4: begin
          a = 32'($urandom_range(8, 63)) << 2;
          busWrite(a[7:0], s, d, "rnd_wr_unmapped");
          busRead(a[7:0], 32'd0, "rnd_rd_unmapped");
        end
        5: begin
          a = $urandom;
          if (a[31:8] == BASE[31:8]) a[31] = ~a[31];
          applyStimulus(a, 4'($urandom_range(0, 15)), d, 32'd0, 1'b0, 1'b0, 1'b0, "rnd_out_of_window");
        end
        default: begin
          gpio_in = GW'(d);
          idle(3);
          busRead(8'h04, d & GMASK, "rnd_rd_gpio_in");
        end
      endcase
    end

    // handshake with valid held after ready
    applyStimulus(BASE, 4'hF, 32'h0000_A5A5, 32'd0, 1'b0, 1'b1, 1'b1, "wr_a5a5");
    checkOutput("gpio_out_a5a5", 32'(gpio_out), 32'h0000_A5A5);
    applyStimulus(BASE, 4'h0, 32'd0, 32'h0000_A5A5, 1'b0, 1'b1, 1'b1, "rd_a5a5");

    // byte strobes and decode
    busWrite(8'h00, 4'hF, 32'd0, "wr_zero");
    busWrite(8'h00, 4'b0010, 32'h1234_5678, "wr_strobe_byte1");
    checkOutput("gpio_out_strobe", 32'(gpio_out), 32'h0000_5600);
    busRead(8'h00, 32'h0000_5600, "rd_strobe_byte1");
    applyStimulus(32'h0400_0000, 4'h0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, "oow_0400");
    busRead(8'h3C, 32'd0, "rd_offset_3c");

    // gpio rising-edge interrupt
    gpio_in = '0;
    idle(4);
    busWrite(8'h08, 4'hF, 32'h0000_0001, "wr_ien_bit0");
    busWrite(8'h0C, 4'hF, 32'hFFFF_FFFF, "clr_all_stat");
    busRead(8'h0C, 32'd0, "stat_cleared");
    idle(2);
    checkOutput("irq_gpio_idle", {31'd0, irq_gpio}, 32'd0);
    gpio_in = GW'(1);
    idle(3);
    checkOutput("irq_gpio_lags_stat", {31'd0, irq_gpio}, 32'd0);
    idle(1);
    checkOutput("irq_gpio_set", {31'd0, irq_gpio}, 32'd1);
    busRead(8'h0C, 32'd1, "stat_rise_bit0");
    gpio_in = GW'(3);
    idle(5);
    busRead(8'h0C, 32'd1, "stat_masked_bit1");
    busWrite(8'h0C, 4'b0010, 32'd1, "w1c_wrong_byte");
    busRead(8'h0C, 32'd1, "stat_kept");
    busWrite(8'h0C, 4'hF, 32'd1, "w1c_stat_bit0");
    idle(4);
    busRead(8'h0C, 32'd0, "stat_no_retrigger");
    checkOutput("irq_gpio_cleared", {31'd0, irq_gpio}, 32'd0);
    gpio_in = GW'(2);
    idle(3);
    gpio_in = GW'(3);
    idle(6);
    checkOutput("irq_gpio_rearmed", {31'd0, irq_gpio}, 32'd1);

    // one-shot timer
    busWrite(8'h14, 4'hF, 32'd5, "wr_load5");
    busRead(8'h18, 32'd5, "count_loaded");
    busWrite(8'h10, 4'hF, 32'h5, "wr_ctrl_oneshot");
    tm_en_edge = last_cap;
    tm_load    = 5;
    tm_reload  = 1'b0;
    repeat (4) readCount("count_oneshot");
    busRead(8'h1C, 32'd1, "expired_oneshot");
    busRead(8'h10, 32'h4, "ctrl_en_cleared");
    checkOutput("irq_timer_oneshot", {31'd0, irq_timer}, 32'd1);
    busWrite(8'h1C, 4'hF, 32'd1, "w1c_expired");
    idle(2);
    checkOutput("irq_timer_cleared", {31'd0, irq_timer}, 32'd0);
    busRead(8'h1C, 32'd0, "expired_cleared");

    // auto-reload timer and same-cycle collisions
    busWrite(8'h14, 4'hF, 32'd3, "wr_load3");
    busWrite(8'h10, 4'hF, 32'h7, "wr_ctrl_reload");
    tm_en_edge = last_cap;
    tm_load    = 3;
    tm_reload  = 1'b1;
    repeat (6) readCount("count_reload");
    while (((cyc + 2 - tm_en_edge) % 3) != 0) idle(1);
    busWrite(8'h1C, 4'hF, 32'd1, "w1c_on_expiry");
    busRead(8'h1C, 32'd1, "expired_set_wins");
    while (((cyc + 2 - tm_en_edge) % 3) != 1) idle(1);
    busWrite(8'h1C, 4'hF, 32'd1, "w1c_off_expiry");
    busRead(8'h1C, 32'd0, "expired_cleared_reload");
    busWrite(8'h14, 4'hF, 32'd10, "wr_load10_running");
    tm_en_edge = last_cap;
    tm_load    = 10;
    readCount("count_load_wins");
    readCount("count_after_load");
    idle(2);
    checkOutput("irq_timer_reload", {31'd0, irq_timer}, 32'd1);

    // reset in the middle of a pending read with the timer running
    busWrite(8'h00, 4'hF, 32'h0000_BEEF, "wr_beef");
    checkOutput("gpio_out_beef", 32'(gpio_out), 32'h0000_BEEF);
    checkOutput("irq_gpio_pre_reset", {31'd0, irq_gpio}, 32'd1);
    @(posedge clk);
    #1;
    iomem_valid = 1'b1;
    iomem_addr  = BASE | 32'h18;
    iomem_wstrb = 4'b0000;
    resetn      = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("midreset_ready", {31'd0, iomem_ready}, 32'd0);
    checkOutput("midreset_rdata", iomem_rdata, 32'd0);
    checkOutput("midreset_gpio_out", 32'(gpio_out), 32'd0);
    checkOutput("midreset_irq_timer", {31'd0, irq_timer}, 32'd0);
    checkOutput("midreset_irq_gpio", {31'd0, irq_gpio}, 32'd0);
    iomem_valid = 1'b0;
    resetn      = 1'b1;
    busRead(8'h18, 32'd0, "count_after_reset");
    busRead(8'h10, 32'd0, "ctrl_after_reset");
    busRead(8'h14, 32'd0, "load_after_reset");

    idle(3);
    checkOutput("scoreboard_drained", 32'(sb_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/iomem_periph.md
Name: iomem_periph

Overview:
Memory-mapped GPIO and timer peripheral that acts as a responder on the SoC's external iomem bus. It occupies a 256-byte window at BASE_ADDR and acknowledges only accesses inside that window. Out-of-window iomem accesses are left for other responders. It drives two level interrupts meant for the CPU's irq_5 (timer) and irq_6 (GPIO) inputs.

Parameters:
BASE_ADDR, 32'h0300_0000, window base; a request is decoded as ours when iomem_addr[31:8] == BASE_ADDR[31:8].
GPIO_WIDTH, 16, number of GPIO outputs and inputs (1..32); register bits above GPIO_WIDTH read 0.

Ports:
clk  input  1  single system clock
resetn  input  1  synchronous, active-low reset
iomem_valid  input  1  request valid; held by the initiator until iomem_ready
iomem_ready  output  1  registered one-cycle acknowledge
iomem_wstrb  input  4  byte write strobes; 0 = read
iomem_addr  input  32  byte address
iomem_wdata  input  32  write data
iomem_rdata  output  32  read data; valid only while iomem_ready=1, otherwise 0
gpio_out  output  GPIO_WIDTH  GPIO_OUT register
gpio_in  input  GPIO_WIDTH  asynchronous inputs
irq_timer  output  1  timer interrupt, level
irq_gpio  output  1  GPIO interrupt, level

Behaviour:
Reset:
- A low resetn at a clk edge clears: iomem_ready, iomem_rdata, gpio_out, all registers, sync flops, irq_timer, irq_gpio.
- Reset mid-access drops iomem_ready and discards the access.

Handshake:
- sel = iomem_valid && in-window && !iomem_ready.
- iomem_ready <= sel. Exactly 1 wait cycle: valid seen at edge N, ready high for the cycle after edge N+1, ready low at the following edge even if valid remains high.
- Writes commit at the same edge that raises ready. Reads capture the register value at that edge into iomem_rdata.
- Out-of-window requests never raise ready.

Register map (offset = addr[7:2]*4; RW registers honour per-byte strobes):
- 0x00 GPIO_OUT, RW.
- 0x04 GPIO_IN, RO. Two-flop synchronised copy of gpio_in.
- 0x08 GPIO_IRQ_EN, RW. Rising-edge enable mask.
- 0x0C GPIO_IRQ_STAT, W1C. A bit is cleared where wdata=1 and its byte strobe is set.
- 0x10 TIMER_CTRL, RW. bit0 EN, bit1 RELOAD, bit2 IRQ_EN; other bits read 0.
- 0x14 TIMER_LOAD, RW. A write also copies the newly written value into COUNT.
- 0x18 TIMER_COUNT, RO.
- 0x1C TIMER_STAT, W1C. bit0 EXPIRED.
- Other offsets read 0; writes are acknowledged and ignored.

GPIO:
- Two-flop synchroniser into sync, then a prev register.
- rise = sync & ~prev.
- STAT <= (STAT & ~clr) | (rise & EN). When a set and a clear hit the same bit in the same cycle, set wins.
- irq_gpio = |STAT, registered one cycle after STAT.

Timer:
- When EN=1 and COUNT!=0, COUNT decrements by 1 per cycle.
- On the step 1→0:
  - EXPIRED <= 1.
  - If RELOAD=1: COUNT <= LOAD instead of 0, giving a period of LOAD cycles.
  - Else: COUNT stays 0 and EN clears.
- EN=1 with COUNT=0 is idle and never expires. LOAD=0 with RELOAD=1 is idle after expiry.
- A TIMER_LOAD write in the same cycle as a decrement: the write wins.
- A W1C of EXPIRED in the same cycle as a new expiry: set wins.
- irq_timer = EXPIRED & IRQ_EN, registered.

Widths: COUNT and LOAD are 32 bits; no wrap below 0.

Test Plan:
- Read/write handshake: write 0xA5A5 to 0x0300_0000 with wstrb=4'hF, then read it back → ready pulses 1 cycle exactly 1 cycle after valid; gpio_out=16'hA5A5; rdata=0x0000A5A5; with valid held, no second ready.
- Byte strobes and decode: write 0x1234_5678 wstrb=4'b0010 to GPIO_OUT (starting at 0) → GPIO_OUT=0x5600. Access 0x0400_0000 → ready never asserts. Read offset 0x3C → 0.
- One-shot timer: LOAD=5, CTRL=0x5 → EXPIRED and irq_timer set after 5 decrements; COUNT=0; EN reads 0. W1C 0x1 to 0x1C → irq_timer drops.
- Auto-reload and collisions: LOAD=3, CTRL=0x7 → expiry every 3 cycles, COUNT sequence 3,2,1,3,2,1. W1C issued on the expiry cycle → EXPIRED stays 1.
- GPIO edge IRQ: IRQ_EN=0x0001, drive gpio_in[0] 0→1 → STAT[0]=1 by the 3rd cycle, then irq_gpio. Edge on bit 1 (masked) → no irq. Hold high → no re-trigger. W1C clears STAT[0].
- Reset mid-operation: assert resetn=0 during a pending read and a running timer → next cycle iomem_ready=0, gpio_out=0, COUNT=0, both irqs=0.
